vga_sync_gen: RTL

- Produces the raster scan position (x, y) and frame_active consumed by overlay_creator and the other pixel generators.
- Generates VGA hsync/vsync with parameterised timing, plus copies of sync and data-enable delayed to match downstream pixel-path latency.
- Provides line/frame start pulses and a free-running frame counter for animation logic.
- Sits at the top of the video path, ahead of overlay_creator and the output compositor.

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_sync_gen_delay.sv | 52 +++++
 rtl/vga_sync_gen.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing: default 640x480@60 constants, coordinate width,
// and helpers that derive totals and sync window bounds from porch widths.
package vga_timing_pkg;

    // Coordinate width shared by every pixel generator that consumes x/y.
    localparam int XY_W   = 10;
    localparam int XY_MAX = 1 << XY_W;

    // Default 640x480@60 (25.175 MHz pixel clock) timing.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    // Sync/de bundle carried through the alignment delay line.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_bus_t;

    // Total counts per line or per frame.
    function automatic int timing_total(input int active, input int front,
                                        input int sync, input int back);
        return active + front + sync + back;
    endfunction

    // First count at which sync is asserted.
    function automatic int sync_start(input int active, input int front);
        return active + front;
    endfunction

    // First count after the sync pulse (exclusive end).
    function automatic int sync_end(input int active, input int front, input int sync);
        return active + front + sync;
    endfunction

endpackage

// File: rtl/vga_sync_gen_delay.sv
// Clock-enabled shift register with a run-time reset value. Used to align
// sync/de with downstream pixel-path latency; DEPTH = 0 is a plain wire.
module sync_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // No stages: control inputs are intentionally ignored.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst_n, en, rst_val};
            assign dout        = din;
        end else begin : g_shift
            logic [DEPTH-1:0][WIDTH-1:0] stage_q;
            logic [DEPTH-1:0][WIDTH-1:0] stage_d;

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                // Next value of each stage: shift only on enable, else hold.
                always_comb begin
                    stage_d[gi] = stage_q[gi];
                    if (en) begin
                        if (gi == 0) begin
                            stage_d[gi] = din;
                        end else begin
                            stage_d[gi] = stage_q[gi-1];
                        end
                    end
                end

                // Stage register, loaded with the idle pattern on reset.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_q[gi] <= rst_val;
                    end else begin
                        stage_q[gi] <= stage_d[gi];
                    end
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: x/y scan position, active-area flag, h/v sync,
// line/frame start pulses, frame counter and latency-matched sync/de copies.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE         = DEF_H_ACTIVE,
    parameter int H_FRONT          = DEF_H_FRONT,
    parameter int H_SYNC           = DEF_H_SYNC,
    parameter int H_BACK           = DEF_H_BACK,
    parameter int V_ACTIVE         = DEF_V_ACTIVE,
    parameter int V_FRONT          = DEF_V_FRONT,
    parameter int V_SYNC           = DEF_V_SYNC,
    parameter int V_BACK           = DEF_V_BACK,
    parameter int SYNC_ACTIVE_HIGH = 0,
    parameter int PIPE_DELAY       = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pix_en,
    output logic [XY_W-1:0] x,
    output logic [XY_W-1:0] y,
    output logic            frame_active,
    output logic            hsync,
    output logic            vsync,
    output logic            hsync_d,
    output logic            vsync_d,
    output logic            de_d,
    output logic            line_start,
    output logic            frame_start,
    output logic [7:0]      frame_count
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    // Compare in XY_W+1 bits so window ends equal to 1024 still fit.
    localparam logic [XY_W:0] H_ACT_C  = (XY_W+1)'(H_ACTIVE);
    localparam logic [XY_W:0] V_ACT_C  = (XY_W+1)'(V_ACTIVE);
    localparam logic [XY_W:0] HS_BEG_C = (XY_W+1)'(sync_start(H_ACTIVE, H_FRONT));
    localparam logic [XY_W:0] HS_END_C = (XY_W+1)'(sync_end(H_ACTIVE, H_FRONT, H_SYNC));
    localparam logic [XY_W:0] VS_BEG_C = (XY_W+1)'(sync_start(V_ACTIVE, V_FRONT));
    localparam logic [XY_W:0] VS_END_C = (XY_W+1)'(sync_end(V_ACTIVE, V_FRONT, V_SYNC));

    localparam logic [XY_W-1:0] X_LAST = XY_W'(H_TOTAL - 1);
    localparam logic [XY_W-1:0] Y_LAST = XY_W'(V_TOTAL - 1);

    localparam logic SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);
    localparam logic SYNC_OFF = ~SYNC_ON;

    // Reject timings the counters cannot represent.
    generate
        if (H_TOTAL > XY_MAX) begin : g_bad_h_total
            $error("vga_sync_gen: H_TOTAL exceeds coordinate range");
        end
        if (V_TOTAL > XY_MAX) begin : g_bad_v_total
            $error("vga_sync_gen: V_TOTAL exceeds coordinate range");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_pipe
            $error("vga_sync_gen: PIPE_DELAY must be 0..4");
        end
    endgenerate

    logic [XY_W-1:0] x_q, x_d;
    logic [XY_W-1:0] y_q, y_d;
    logic            act_q, act_d;
    logic            hs_q, hs_d;
    logic            vs_q, vs_d;
    logic            line_start_q, line_start_d;
    logic            frame_start_q, frame_start_d;
    logic [7:0]      frame_count_q, frame_count_d;

    // Advance the raster on pix_en; decode flags from the new position so
    // they stay aligned with x/y. Start pulses default low every clk.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        act_d         = act_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;

        if (pix_en) begin
            if (x_q == X_LAST) begin
                x_d          = '0;
                line_start_d = 1'b1;
                if (y_q == Y_LAST) begin
                    y_d           = '0;
                    frame_start_d = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end

            act_d = ({1'b0, x_d} < H_ACT_C) && ({1'b0, y_d} < V_ACT_C);
            hs_d  = (({1'b0, x_d} >= HS_BEG_C) && ({1'b0, x_d} < HS_END_C)) ? SYNC_ON : SYNC_OFF;
            vs_d  = (({1'b0, y_d} >= VS_BEG_C) && ({1'b0, y_d} < VS_END_C)) ? SYNC_ON : SYNC_OFF;
        end
    end

    // Raster state; reset parks on the last pixel so the first pix_en lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= X_LAST;
            y_q           <= Y_LAST;
            act_q         <= 1'b0;
            hs_q          <= SYNC_OFF;
            vs_q          <= SYNC_OFF;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            act_q         <= act_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    sync_bus_t dly_in;
    sync_bus_t dly_rst;
    sync_bus_t dly_out;

    assign dly_in  = '{hsync: hs_q, vsync: vs_q, de: act_q};
    assign dly_rst = '{hsync: SYNC_OFF, vsync: SYNC_OFF, de: 1'b0};

    sync_delay_line #(
        .DEPTH (PIPE_DELAY),
        .WIDTH ($bits(sync_bus_t))
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (pix_en),
        .rst_val (dly_rst),
        .din     (dly_in),
        .dout    (dly_out)
    );

    assign x            = x_q;
    assign y            = y_q;
    assign frame_active = act_q;
    assign hsync        = hs_q;
    assign vsync        = vs_q;
    assign hsync_d      = dly_out.hsync;
    assign vsync_d      = dly_out.vsync;
    assign de_d         = dly_out.de;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign frame_count  = frame_count_q;

endmodule
